// File: rtl/exec_stage.sv
// Execute stage of the cpu15 pipeline: single-cycle ALU, iterative
// one-bit-per-cycle shifter, compare/jump control and sticky halt.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_IDLE   | ready for a new instruction; single-cycle ops finish here
//   S_SHIFT  | variable shift in progress, decode stalled
//   S_HALTED | HLT retired; only reset leaves this state
module exec_stage (
    input  logic        CLK_EX,
    input  logic        RESET_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [3:0]  OP_CODE,
    input  logic [2:0]  N_REG_IN,
    input  logic [15:0] REG_A,
    input  logic [15:0] REG_B,
    input  logic [7:0]  IMM,
    output logic        OUT_VALID,
    output logic [2:0]  N_REG_OUT,
    output logic [15:0] RESULT,
    output logic        WE,
    output logic        JUMP,
    output logic [7:0]  JUMP_ADDR,
    output logic        ZF,
    output logic        HALT
);

    localparam logic [3:0] OP_MOV = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SL  = 4'd6;
    localparam logic [3:0] OP_SR  = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_LDL = 4'd9;
    localparam logic [3:0] OP_LDH = 4'd10;
    localparam logic [3:0] OP_CMP = 4'd11;
    localparam logic [3:0] OP_JE  = 4'd12;
    localparam logic [3:0] OP_JMP = 4'd13;
    localparam logic [3:0] OP_HLT = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HALTED} state_t;

    state_t      state_q;
    logic        out_valid_q;
    logic [2:0]  n_reg_out_q;
    logic [15:0] result_q;
    logic        we_q;
    logic        jump_q;
    logic [7:0]  jump_addr_q;
    logic        zf_q;
    logic        halt_q;
    logic [15:0] sh_q;
    logic [3:0]  cnt_q;
    logic [3:0]  sh_op_q;
    logic [2:0]  sh_dst_q;

    logic [15:0] alu_result_d;
    logic        alu_we_d;
    logic        alu_jump_d;
    logic [7:0]  alu_jump_addr_d;
    logic [15:0] sh_d;
    logic        is_shift;
    logic        accept;

    assign IN_READY  = (state_q == S_IDLE) && !halt_q;
    assign accept    = IN_VALID && IN_READY;
    assign is_shift  = (OP_CODE == OP_SL) || (OP_CODE == OP_SR) || (OP_CODE == OP_SRA);

    assign OUT_VALID = out_valid_q;
    assign N_REG_OUT = n_reg_out_q;
    assign RESULT    = result_q;
    assign WE        = we_q;
    assign JUMP      = jump_q;
    assign JUMP_ADDR = jump_addr_q;
    assign ZF        = zf_q;
    assign HALT      = halt_q;

    // Single-cycle result; a zero-count shift passes operand A through.
    always_comb begin
        alu_result_d    = 16'h0000;
        alu_we_d        = (OP_CODE <= OP_LDH);
        alu_jump_d      = 1'b0;
        alu_jump_addr_d = 8'h00;
        case (OP_CODE)
            OP_MOV:                 alu_result_d = REG_B;
            OP_ADD:                 alu_result_d = REG_A + REG_B;
            OP_SUB:                 alu_result_d = REG_A - REG_B;
            OP_AND:                 alu_result_d = REG_A & REG_B;
            OP_OR:                  alu_result_d = REG_A | REG_B;
            OP_XOR:                 alu_result_d = REG_A ^ REG_B;
            OP_SL, OP_SR, OP_SRA:   alu_result_d = REG_A;
            OP_LDL:                 alu_result_d = {REG_A[15:8], IMM};
            OP_LDH:                 alu_result_d = {IMM, REG_A[7:0]};
            OP_JE: begin
                alu_jump_d      = zf_q;
                alu_jump_addr_d = IMM;
            end
            OP_JMP: begin
                alu_jump_d      = 1'b1;
                alu_jump_addr_d = IMM;
            end
            default: ;
        endcase
    end

    // One-bit step of the iterative shifter.
    always_comb begin
        sh_d = sh_q;
        case (sh_op_q)
            OP_SL:   sh_d = {sh_q[14:0], 1'b0};
            OP_SR:   sh_d = {1'b0, sh_q[15:1]};
            OP_SRA:  sh_d = {sh_q[15], sh_q[15:1]};
            default: sh_d = sh_q;
        endcase
    end

    // Stage FSM with registered writeback packet and control outputs.
    always_ff @(posedge CLK_EX) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            n_reg_out_q <= 3'd0;
            result_q    <= 16'h0000;
            we_q        <= 1'b0;
            jump_q      <= 1'b0;
            jump_addr_q <= 8'h00;
            zf_q        <= 1'b0;
            halt_q      <= 1'b0;
            sh_q        <= 16'h0000;
            cnt_q       <= 4'd0;
            sh_op_q     <= 4'd0;
            sh_dst_q    <= 3'd0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (is_shift && (REG_B[3:0] != 4'd0)) begin
                            sh_q     <= REG_A;
                            cnt_q    <= REG_B[3:0];
                            sh_op_q  <= OP_CODE;
                            sh_dst_q <= N_REG_IN;
                            state_q  <= S_SHIFT;
                        end else begin
                            out_valid_q <= 1'b1;
                            n_reg_out_q <= N_REG_IN;
                            result_q    <= alu_result_d;
                            we_q        <= alu_we_d;
                            jump_q      <= alu_jump_d;
                            jump_addr_q <= alu_jump_addr_d;
                            if (OP_CODE == OP_CMP) begin
                                zf_q <= (REG_A == REG_B);
                            end
                            if (OP_CODE == OP_HLT) begin
                                halt_q  <= 1'b1;
                                state_q <= S_HALTED;
                            end
                        end
                    end
                end
                S_SHIFT: begin
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        out_valid_q <= 1'b1;
                        n_reg_out_q <= sh_dst_q;
                        result_q    <= sh_d;
                        we_q        <= 1'b1;
                        jump_q      <= 1'b0;
                        jump_addr_q <= 8'h00;
                        state_q     <= S_IDLE;
                    end
                end
                S_HALTED: state_q <= S_HALTED;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage; inputs change and outputs are sampled on
// the falling edge, half a period away from the rising active edge.
module tb_exec_stage;

    logic        CLK_EX = 1'b0;
    logic        RESET_N = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [3:0]  OP_CODE = 4'd14;
    logic [2:0]  N_REG_IN = 3'd0;
    logic [15:0] REG_A = 16'h0;
    logic [15:0] REG_B = 16'h0;
    logic [7:0]  IMM = 8'h0;
    logic        OUT_VALID;
    logic [2:0]  N_REG_OUT;
    logic [15:0] RESULT;
    logic        WE;
    logic        JUMP;
    logic [7:0]  JUMP_ADDR;
    logic        ZF;
    logic        HALT;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  dst;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  imm;
        logic [15:0] exp;
    } vec_t;

    exec_stage dut (
        .CLK_EX(CLK_EX), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OP_CODE(OP_CODE), .N_REG_IN(N_REG_IN), .REG_A(REG_A), .REG_B(REG_B), .IMM(IMM),
        .OUT_VALID(OUT_VALID), .N_REG_OUT(N_REG_OUT), .RESULT(RESULT), .WE(WE),
        .JUMP(JUMP), .JUMP_ADDR(JUMP_ADDR), .ZF(ZF), .HALT(HALT)
    );

    always #5 CLK_EX = ~CLK_EX;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [3:0] op, input logic [2:0] dst, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] imm);
        IN_VALID = 1'b1; OP_CODE = op; N_REG_IN = dst; REG_A = a; REG_B = b; IMM = imm;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        drive(4'd1, 3'd7, 16'h1234, 16'h1111, 8'h55);
        repeat (3) @(negedge CLK_EX);
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", OUT_VALID); end
        checks++; if (RESULT !== 16'h0) begin errors++; $display("FAIL reset_result: got %h want 0000", RESULT); end
        checks++; if ({WE, JUMP, ZF, HALT} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {WE, JUMP, ZF, HALT}); end
        checks++; if ({N_REG_OUT, JUMP_ADDR} !== 11'h0) begin errors++; $display("FAIL reset_idx_addr: got %h want 000", {N_REG_OUT, JUMP_ADDR}); end
        IN_VALID = 1'b0;
        RESET_N = 1'b1;
        @(negedge CLK_EX);
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", IN_READY); end
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_no_valid: got %b want 0", OUT_VALID); end
    endtask

    task automatic test_add();
        @(negedge CLK_EX);
        drive(4'd1, 3'd3, 16'hFFFF, 16'h0002, 8'h00);
        @(negedge CLK_EX);
        IN_VALID = 1'b0;
        checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", OUT_VALID); end
        checks++; if (RESULT !== 16'h0001) begin errors++; $display("FAIL add_result: got %h want 0001", RESULT); end
        checks++; if (WE !== 1'b1) begin errors++; $display("FAIL add_we: got %b want 1", WE); end
        checks++; if (N_REG_OUT !== 3'd3) begin errors++; $display("FAIL add_dst: got %0d want 3", N_REG_OUT); end
        @(negedge CLK_EX);
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL add_pulse: got %b want 0", OUT_VALID); end
        checks++; if ({RESULT, WE} !== {16'h0001, 1'b1}) begin errors++; $display("FAIL add_hold: got %h want 00011", {RESULT, WE}); end
    endtask

    task automatic test_back_to_back();
        vec_t v[9];
        v[0] = '{4'd0,  3'd1, 16'h1111, 16'hBEEF, 8'h00, 16'hBEEF};
        v[1] = '{4'd2,  3'd2, 16'h0001, 16'h0002, 8'h00, 16'hFFFF};
        v[2] = '{4'd3,  3'd3, 16'hF0F0, 16'h3C3C, 8'h00, 16'h3030};
        v[3] = '{4'd4,  3'd4, 16'hF0F0, 16'h0F00, 8'h00, 16'hFFF0};
        v[4] = '{4'd5,  3'd5, 16'hAAAA, 16'hFFFF, 8'h00, 16'h5555};
        v[5] = '{4'd10, 3'd6, 16'h00CD, 16'h0000, 8'hAB, 16'hABCD};
        v[6] = '{4'd9,  3'd7, 16'hAB00, 16'h0000, 8'hCD, 16'hABCD};
        v[7] = '{4'd6,  3'd0, 16'h1234, 16'hFFF0, 8'h00, 16'h1234};
        v[8] = '{4'd8,  3'd1, 16'h8001, 16'h0010, 8'h00, 16'h8001};
        for (int i = 0; i <= 9; i++) begin
            @(negedge CLK_EX);
            if (i > 0) begin
                checks++; if ({OUT_VALID, WE} !== 2'b11) begin errors++; $display("FAIL b2b_valid_we[%0d]: got %b want 11", i-1, {OUT_VALID, WE}); end
                checks++; if (RESULT !== v[i-1].exp) begin errors++; $display("FAIL b2b_result[%0d]: got %h want %h", i-1, RESULT, v[i-1].exp); end
                checks++; if (N_REG_OUT !== v[i-1].dst) begin errors++; $display("FAIL b2b_dst[%0d]: got %0d want %0d", i-1, N_REG_OUT, v[i-1].dst); end
            end
            if (i < 9) begin
                checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, IN_READY); end
                drive(v[i].op, v[i].dst, v[i].a, v[i].b, v[i].imm);
            end else begin
                IN_VALID = 1'b0;
            end
        end
    endtask

    task automatic test_shift_sra();
        @(negedge CLK_EX);
        drive(4'd8, 3'd5, 16'h8000, 16'h0004, 8'h00);
        @(negedge CLK_EX);
        drive(4'd0, 3'd2, 16'h0000, 16'h7777, 8'h00);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge CLK_EX);
            checks++; if ({IN_READY, OUT_VALID} !== 2'b00) begin errors++; $display("FAIL sra_stall[%0d]: got %b want 00", c, {IN_READY, OUT_VALID}); end
        end
        @(negedge CLK_EX);
        checks++; if ({OUT_VALID, IN_READY, WE} !== 3'b111) begin errors++; $display("FAIL sra_done: got %b want 111", {OUT_VALID, IN_READY, WE}); end
        checks++; if (RESULT !== 16'hF800) begin errors++; $display("FAIL sra_result: got %h want F800", RESULT); end
        checks++; if (N_REG_OUT !== 3'd5) begin errors++; $display("FAIL sra_dst: got %0d want 5", N_REG_OUT); end
        @(negedge CLK_EX);
        IN_VALID = 1'b0;
        checks++; if ({OUT_VALID, RESULT, N_REG_OUT} !== {1'b1, 16'h7777, 3'd2}) begin errors++; $display("FAIL sra_next_mov: got %h want %h", {OUT_VALID, RESULT, N_REG_OUT}, {1'b1, 16'h7777, 3'd2}); end
    endtask

    task automatic test_shift_vectors();
        vec_t v[4];
        int lat;
        v[0] = '{4'd7, 3'd1, 16'hF000, 16'h0013, 8'h00, 16'h1E00};
        v[1] = '{4'd6, 3'd2, 16'h0003, 16'h0002, 8'h00, 16'h000C};
        v[2] = '{4'd8, 3'd3, 16'h4000, 16'h0001, 8'h00, 16'h2000};
        v[3] = '{4'd6, 3'd4, 16'h0001, 16'h000F, 8'h00, 16'h8000};
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK_EX);
            drive(v[i].op, v[i].dst, v[i].a, v[i].b, v[i].imm);
            @(negedge CLK_EX);
            IN_VALID = 1'b0;
            lat = 0;
            while (OUT_VALID !== 1'b1 && lat < 20) begin
                @(negedge CLK_EX);
                lat++;
            end
            checks++; if (lat !== int'(v[i].b[3:0])) begin errors++; $display("FAIL shift_latency[%0d]: got %0d want %0d", i, lat, v[i].b[3:0]); end
            checks++; if ({RESULT, N_REG_OUT} !== {v[i].exp, v[i].dst}) begin errors++; $display("FAIL shift_result[%0d]: got %h want %h", i, {RESULT, N_REG_OUT}, {v[i].exp, v[i].dst}); end
        end
    endtask

    task automatic test_cmp_je();
        logic [15:0] bval;
        logic        zexp;
        for (int r = 0; r < 2; r++) begin
            bval = (r == 0) ? 16'h1234 : 16'h1235;
            zexp = (r == 0);
            @(negedge CLK_EX);
            drive(4'd11, 3'd1, 16'h1234, bval, 8'h00);
            @(negedge CLK_EX);
            checks++; if ({OUT_VALID, WE, JUMP, ZF} !== {3'b100, zexp}) begin errors++; $display("FAIL cmp_flags[%0d]: got %b want %b", r, {OUT_VALID, WE, JUMP, ZF}, {3'b100, zexp}); end
            checks++; if (RESULT !== 16'h0) begin errors++; $display("FAIL cmp_result[%0d]: got %h want 0000", r, RESULT); end
            drive(4'd12, 3'd2, 16'h0000, 16'h0000, 8'h2A);
            @(negedge CLK_EX);
            IN_VALID = 1'b0;
            checks++; if ({OUT_VALID, WE, JUMP} !== {2'b10, zexp}) begin errors++; $display("FAIL je_jump[%0d]: got %b want %b", r, {OUT_VALID, WE, JUMP}, {2'b10, zexp}); end
            checks++; if (JUMP_ADDR !== 8'h2A) begin errors++; $display("FAIL je_addr[%0d]: got %h want 2A", r, JUMP_ADDR); end
        end
        @(negedge CLK_EX);
        drive(4'd13, 3'd0, 16'h0000, 16'h0000, 8'h55);
        @(negedge CLK_EX);
        drive(4'd14, 3'd0, 16'h0000, 16'h0000, 8'h66);
        checks++; if ({OUT_VALID, JUMP, JUMP_ADDR, ZF} !== {2'b11, 8'h55, 1'b0}) begin errors++; $display("FAIL jmp: got %h want %h", {OUT_VALID, JUMP, JUMP_ADDR, ZF}, {2'b11, 8'h55, 1'b0}); end
        @(negedge CLK_EX);
        IN_VALID = 1'b0;
        checks++; if ({OUT_VALID, WE, JUMP, JUMP_ADDR, RESULT} !== {3'b100, 8'h00, 16'h0}) begin errors++; $display("FAIL nop: got %h want %h", {OUT_VALID, WE, JUMP, JUMP_ADDR, RESULT}, {3'b100, 8'h00, 16'h0}); end
    endtask

    task automatic test_shift_reset();
        int seen;
        @(negedge CLK_EX);
        drive(4'd6, 3'd4, 16'h0001, 16'h000F, 8'h00);
        @(negedge CLK_EX);
        IN_VALID = 1'b0;
        repeat (2) @(negedge CLK_EX);
        checks++; if ({IN_READY, OUT_VALID} !== 2'b00) begin errors++; $display("FAIL slr_busy: got %b want 00", {IN_READY, OUT_VALID}); end
        RESET_N = 1'b0;
        @(negedge CLK_EX);
        RESET_N = 1'b1;
        checks++; if ({OUT_VALID, RESULT} !== 17'h0) begin errors++; $display("FAIL slr_cleared: got %h want 00000", {OUT_VALID, RESULT}); end
        seen = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK_EX);
            if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL slr_aborted: got %0d bad cycles want 0", seen); end
        drive(4'd0, 3'd6, 16'h0000, 16'h0BAD, 8'h00);
        @(negedge CLK_EX);
        IN_VALID = 1'b0;
        checks++; if ({OUT_VALID, WE, RESULT, N_REG_OUT} !== {2'b11, 16'h0BAD, 3'd6}) begin errors++; $display("FAIL slr_mov: got %h want %h", {OUT_VALID, WE, RESULT, N_REG_OUT}, {2'b11, 16'h0BAD, 3'd6}); end
    endtask

    task automatic test_halt();
        int bad;
        @(negedge CLK_EX);
        drive(4'd15, 3'd0, 16'h0000, 16'h0000, 8'h00);
        @(negedge CLK_EX);
        drive(4'd1, 3'd2, 16'h0001, 16'h0001, 8'h00);
        checks++; if ({OUT_VALID, WE, JUMP, HALT, IN_READY} !== 5'b10010) begin errors++; $display("FAIL hlt_pulse: got %b want 10010", {OUT_VALID, WE, JUMP, HALT, IN_READY}); end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK_EX);
            if (IN_READY !== 1'b0 || OUT_VALID !== 1'b0 || HALT !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hlt_stuck: got %0d bad cycles want 0", bad); end
        IN_VALID = 1'b0;
        RESET_N = 1'b0;
        @(negedge CLK_EX);
        RESET_N = 1'b1;
        checks++; if (HALT !== 1'b0) begin errors++; $display("FAIL hlt_reset: got %b want 0", HALT); end
        @(negedge CLK_EX);
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL hlt_ready: got %b want 1", IN_READY); end
        drive(4'd1, 3'd7, 16'h0100, 16'h0023, 8'h00);
        @(negedge CLK_EX);
        IN_VALID = 1'b0;
        checks++; if ({OUT_VALID, RESULT, N_REG_OUT} !== {1'b1, 16'h0123, 3'd7}) begin errors++; $display("FAIL hlt_after: got %h want %h", {OUT_VALID, RESULT, N_REG_OUT}, {1'b1, 16'h0123, 3'd7}); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_shift_sra();
        test_shift_vectors();
        test_cmp_je();
        test_shift_reset();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_stage.md
# exec_stage

Execute stage of the cpu15 pipeline, directly downstream of the register decode stage. It accepts a decoded instruction (opcode, destination register index, two 16-bit operands, 8-bit immediate) and produces a registered writeback packet (destination index, result, write enable) plus jump and halt control for the fetch stage. Single-cycle ALU ops complete in one cycle. Variable shifts run iteratively, one bit per cycle, with a valid/ready handshake that stalls decode while the shift is in progress.

## Interface
- No parameters. The data width is fixed at 16 bits, register index at 3 bits, immediate and jump address at 8 bits.
- CLK_EX  in  1  stage clock, rising edge.
- RESET_N  in  1  reset, synchronous, active-low. One clock; reset is sampled only on rising CLK_EX.
- IN_VALID  in  1  decode presents an instruction.
- IN_READY  out  1  stage can accept this cycle. Transfer occurs when IN_VALID && IN_READY at the rising edge.
- OP_CODE  in  4  operation, see Operation.
- N_REG_IN  in  3  destination register index.
- REG_A  in  16  operand A, the destination register's current value.
- REG_B  in  16  operand B.
- IMM  in  8  immediate or jump target.
- OUT_VALID  out  1  one-cycle pulse; writeback packet is valid.
- N_REG_OUT  out  3  destination index for writeback.
- RESULT  out  16  writeback data.
- WE  out  1  register write enable, qualified by OUT_VALID.
- JUMP  out  1  jump taken, qualified by OUT_VALID.
- JUMP_ADDR  out  8  jump target.
- ZF  out  1  compare flag.
- HALT  out  1  sticky halt.

## Operation
- Opcode map (R is the result, arithmetic is mod 2^16):
  - 0 MOV: R=B.
  - 1 ADD: R=A+B, carry discarded.
  - 2 SUB: R=A-B, borrow discarded.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SL: A<<B[3:0].
  - 7 SR: logical right shift.
  - 8 SRA: arithmetic right shift, sign bit replicated.
  - 9 LDL: R={A[15:8],IMM}.
  - 10 LDH: R={IMM,A[7:0]}.
  - 11 CMP: ZF<=(A==B).
  - 12 JE: JUMP=ZF.
  - 13 JMP: JUMP=1.
  - 14 NOP.
  - 15 HLT.
- WE=1 for opcodes 0–10 only. For CMP, JE, JMP, NOP and HLT, WE=0 and RESULT=0.
- JUMP_ADDR=IMM for JE and JMP, otherwise 0.
- Only B[3:0] is used as the shift count; B[15:4] is ignored.
- FSM states: IDLE, SHIFT, HALTED.
  - IDLE: IN_READY=!HALT.
    - On accept of a non-shift op, or a shift with count 0: register the outputs at the accept edge and stay in IDLE.
    - On accept of a shift with count n≥1: load the shift register with A and the counter with n, then go to SHIFT.
    - On accept of HLT: set HALT, emit the OUT_VALID pulse, go to HALTED.
  - SHIFT: IN_READY=0. Shift one bit per edge and decrement the counter. When the counter goes 1→0, register the final result, assert OUT_VALID and return to IDLE.
  - HALTED: IN_READY=0, OUT_VALID=0. Only reset leaves this state.
- ZF is updated only by CMP, at its accept edge, and holds otherwise. A JE accepted in the cycle directly after a CMP sees the new ZF.
- N_REG_OUT, RESULT, WE, JUMP and JUMP_ADDR hold their last values while OUT_VALID=0.

## Timing
- Reset (RESET_N=0 at a rising edge): state to IDLE; all outputs to 0, including ZF, HALT and OUT_VALID; IN_READY=1 from the cycle after reset deasserts. A reset during SHIFT aborts the shift with no OUT_VALID. A reset while HALTED clears HALT.
- Latency: an instruction accepted at edge k presents OUT_VALID during the cycle after edge k+n, where n is the shift count (0 for non-shift ops). Throughput is one instruction per cycle for non-shift ops.
- IN_READY is 1 during the OUT_VALID cycle of a completed shift, so back-to-back accept is allowed on that edge.
- There is no output backpressure. OUT_VALID is exactly one cycle per accepted instruction.
- IN_VALID with IN_READY=0 is ignored; inputs are not captured.
- HALT rises at the HLT accept edge. The HLT OUT_VALID pulse has WE=0 and JUMP=0.

## Test plan
- Reset then ADD, A=0xFFFF, B=0x0002, N_REG_IN=3 -> OUT_VALID for one cycle with RESULT=0x0001, WE=1, N_REG_OUT=3; all outputs 0 during reset.
- SRA, A=0x8000, B=0x0004, held valid -> IN_READY low for 4 cycles; OUT_VALID 5 cycles after the accept edge with RESULT=0xF800; next instruction accepted on the OUT_VALID edge. SL with B=0xFFF0 (count 0) -> RESULT=A at latency 1.
- CMP, A=B=0x1234, then JE, IMM=0x2A on the next cycle -> ZF=1, JUMP=1, JUMP_ADDR=0x2A, WE=0. Repeat with A≠B -> JUMP=0.
- LDH, A=0x00CD, IMM=0xAB -> RESULT=0xABCD. LDL, A=0xAB00, IMM=0xCD -> RESULT=0xABCD.
- SL, A=0x0001, B=0x000F; RESET_N low after 3 shift cycles -> no OUT_VALID; IDLE with IN_READY=1 after reset; a following MOV completes normally.
- HLT -> one OUT_VALID with WE=0 and HALT=1; IN_READY stays 0 for 20 cycles while IN_VALID is held; reset clears HALT.
